// File: rtl/ram_noc_pkg.sv
// Field layout helpers shared by the RAM request/response path.
// Request {wr, rd, src, addr, data}; response {src, data}.
package ram_noc_pkg;

  function automatic int packed_in_w(int w, int aw, int naw);
    return w + aw + naw + 2;
  endfunction

  function automatic int packed_out_w(int w, int naw);
    return w + naw;
  endfunction

  function automatic int rd_pos(int w, int aw, int naw);
    return w + aw + naw;
  endfunction

  function automatic int wr_pos(int w, int aw, int naw);
    return w + aw + naw + 1;
  endfunction

  function automatic int req_src_lsb(int w, int aw);
    return w + aw;
  endfunction

  function automatic int req_addr_lsb(int w);
    return w;
  endfunction

  function automatic int rsp_src_lsb(int w);
    return w;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Timestamp FIFO holding issue times of outstanding reads.
// Push into a full FIFO or pop from an empty one is ignored.
module ts_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_req_tracker.sv
// Per-client read limiter: caps outstanding RAM reads, matches
// responses in order and collects latency/status statistics.
module ram_req_tracker
  import ram_noc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int N          = 16,
  parameter int NODE       = 0,
  parameter int MAX_OUT    = 4,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 32,
  localparam int NAW  = $clog2(N),
  localparam int PIN  = packed_in_w(WIDTH, ADDR_WIDTH, NAW),
  localparam int POUT = packed_out_w(WIDTH, NAW),
  localparam int OW   = $clog2(MAX_OUT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIN-1:0]       s_packed_in,
  input  logic [NAW-1:0]       s_dest_in,
  input  logic                 s_valid_in,
  output logic                 s_ready_out,
  output logic [PIN-1:0]       m_packed_out,
  output logic [NAW-1:0]       m_dest_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  input  logic [POUT-1:0]      r_packed_in,
  input  logic                 r_valid_in,
  output logic                 r_ready_out,
  output logic [POUT-1:0]      c_packed_out,
  output logic                 c_valid_out,
  input  logic                 c_ready_in,
  output logic [OW-1:0]        rd_outstanding,
  output logic [CNT_WIDTH-1:0] rd_issued,
  output logic [CNT_WIDTH-1:0] wr_issued,
  output logic [CNT_WIDTH-1:0] rsp_count,
  output logic [TS_WIDTH-1:0]  lat_last,
  output logic [TS_WIDTH-1:0]  lat_max,
  output logic [CNT_WIDTH-1:0] lat_sum,
  output logic                 err_unexpected,
  output logic                 err_src
);

  localparam int RDB = rd_pos(WIDTH, ADDR_WIDTH, NAW);
  localparam int WRB = wr_pos(WIDTH, ADDR_WIDTH, NAW);
  localparam int SRB = rsp_src_lsb(WIDTH);
  localparam int SW  = CNT_WIDTH + 1;

  logic                 is_rd, is_wr, blk;
  logic                 rd_fire, wr_fire, rsp_fire, match;
  logic                 full, empty, src_bad;
  logic [TS_WIDTH-1:0]  ts_q, stamp, lat;
  logic [SW-1:0]        sum_ext;

  logic [CNT_WIDTH-1:0] rd_iss_q, rd_iss_d;
  logic [CNT_WIDTH-1:0] wr_iss_q, wr_iss_d;
  logic [CNT_WIDTH-1:0] rsp_q, rsp_d;
  logic [CNT_WIDTH-1:0] sum_q, sum_d;
  logic [TS_WIDTH-1:0]  last_q, last_d;
  logic [TS_WIDTH-1:0]  max_q, max_d;
  logic                 eu_q, eu_d;
  logic                 es_q, es_d;

  // rd=wr=1 is treated as a read; only pure writes count as writes
  assign is_rd = s_packed_in[RDB];
  assign is_wr = s_packed_in[WRB] & ~is_rd;
  assign blk   = is_rd & full;

  assign m_packed_out = s_packed_in;
  assign m_dest_out   = s_dest_in;
  assign m_valid_out  = s_valid_in & ~blk;
  assign s_ready_out  = m_ready_in & ~blk;

  assign c_packed_out = r_packed_in;
  assign c_valid_out  = r_valid_in;
  assign r_ready_out  = c_ready_in;

  assign rd_fire  = s_valid_in & s_ready_out & is_rd;
  assign wr_fire  = s_valid_in & s_ready_out & is_wr;
  assign rsp_fire = r_valid_in & c_ready_in;
  assign match    = rsp_fire & ~empty;
  assign src_bad  = r_packed_in[SRB +: NAW] != NAW'(NODE);
  assign lat      = ts_q - stamp;
  assign sum_ext  = {1'b0, sum_q} + SW'(lat);

  ts_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_fire),
    .pop_i   (match),
    .din_i   (ts_q),
    .dout_o  (stamp),
    .count_o (rd_outstanding),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rd_iss_d = rd_iss_q;
    wr_iss_d = wr_iss_q;
    rsp_d    = rsp_q;
    sum_d    = sum_q;
    last_d   = last_q;
    max_d    = max_q;
    eu_d     = eu_q;
    es_d     = es_q;
    if (rd_fire && !(&rd_iss_q)) rd_iss_d = rd_iss_q + CNT_WIDTH'(1);
    if (wr_fire && !(&wr_iss_q)) wr_iss_d = wr_iss_q + CNT_WIDTH'(1);
    if (rsp_fire && src_bad) es_d = 1'b1;
    if (rsp_fire && empty) eu_d = 1'b1;
    if (match) begin
      last_d = lat;
      if (lat > max_q) max_d = lat;
      sum_d = sum_ext[SW-1] ? '1 : sum_ext[CNT_WIDTH-1:0];
      if (!(&rsp_q)) rsp_d = rsp_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      rd_iss_q <= '0;
      wr_iss_q <= '0;
      rsp_q    <= '0;
      sum_q    <= '0;
      last_q   <= '0;
      max_q    <= '0;
      eu_q     <= 1'b0;
      es_q     <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      rd_iss_q <= rd_iss_d;
      wr_iss_q <= wr_iss_d;
      rsp_q    <= rsp_d;
      sum_q    <= sum_d;
      last_q   <= last_d;
      max_q    <= max_d;
      eu_q     <= eu_d;
      es_q     <= es_d;
    end
  end

  assign rd_issued      = rd_iss_q;
  assign wr_issued      = wr_iss_q;
  assign rsp_count      = rsp_q;
  assign lat_sum        = sum_q;
  assign lat_last       = last_q;
  assign lat_max        = max_q;
  assign err_unexpected = eu_q;
  assign err_src        = es_q;

endmodule
